// File: rtl/seg7_display_ctrl.sv
// Multi-digit hex seven-segment controller: load handshake, LZ blanking, blink.
// Optional SEG7_DIM_EN adds a PWM brightness gate driven by dim_level.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int DIM_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [DIM_BITS-1:0]     dim_level,
  output logic                    load_ack,
  output logic                    blink_phase,
  output logic [8*NUM_DIGITS-1:0] seg_out
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dots_q;
  logic                    lz_q;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [CW-1:0]           blink_cnt;
  logic [CW-1:0]           cnt_d;
  logic                    phase_d;
  logic                    wrap;
  logic                    dim_dark;
  logic [NUM_DIGITS-1:0]   zero_run;
  logic [8*NUM_DIGITS-1:0] seg_d;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      dots_q   <= '0;
      lz_q     <= 1'b0;
      mask_q   <= '0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= load;
      if (load) begin
        value_q <= value;
        dots_q  <= dots;
        lz_q    <= lz_en;
        mask_q  <= blink_mask;
      end
    end
  end

  assign wrap = (blink_cnt == CNT_MAX);

  always_comb begin
    cnt_d   = wrap ? '0 : blink_cnt + 1'b1;
    phase_d = wrap ? ~blink_phase : blink_phase;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_cnt   <= cnt_d;
      blink_phase <= phase_d;
    end
  end

`ifdef SEG7_DIM_EN
  logic [DIM_BITS-1:0] pwm_cnt;
  logic [DIM_BITS-1:0] pwm_d;

  assign pwm_d    = pwm_cnt + 1'b1;
  assign dim_dark = (pwm_d >= dim_level);

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_d;
  end
`else
  logic unused_dim;
  assign unused_dim = ^dim_level;
  assign dim_dark   = 1'b0;
`endif

  // zero_run[i]: nibble i and every higher nibble are zero
  always_comb begin
    logic run;
    run      = 1'b1;
    zero_run = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run         = run & (value_q[4*i +: 4] == 4'h0);
      zero_run[i] = run;
    end
  end

  // next-phase/next-pwm keep the registered segments aligned with blink_phase
  always_comb begin
    seg_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (phase_d && mask_q[i])
        seg_d[8*i +: 8] = 8'hFF;
      else if (dim_dark)
        seg_d[8*i +: 8] = 8'hFF;
      else if (lz_q && (i != 0) && zero_run[i])
        seg_d[8*i +: 8] = {~dots_q[i], 7'h7F};
      else
        seg_d[8*i +: 8] = {~dots_q[i], hex7(value_q[4*i +: 4])};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) seg_out <= '1;
    else     seg_out <= seg_d;
  end

endmodule
